// File: rtl/bbc_keyboard_matrix_pkg.sv
// -----------------------------------------------------------------------------
// bbc_keyboard_matrix_pkg
//
// Shared definitions for the BBC micro keyboard matrix model:
//   - matrix geometry (8 rows x 16 addressable columns)
//   - KEY_CODE / PA_IN field layout: {row[2:0], col[3:0]}
//   - named key codes used by the host-side translator and the bench
//   - the column span that carries the startup link (DIP) bits on row 0
// -----------------------------------------------------------------------------
package bbc_keyboard_matrix_pkg;

  // Matrix geometry.
  localparam int KB_ROWS     = 8;
  localparam int KB_COLS_MAX = 16;

  // Key code field positions. PA_IN[6:0] uses the same layout.
  localparam int COL_LSB    = 0;
  localparam int COL_W      = 4;
  localparam int ROW_LSB    = 4;
  localparam int ROW_W      = 3;
  localparam int KEY_CODE_W = ROW_W + COL_W;

  // Row 0 columns 2..9 are the startup links rather than keys.
  localparam int DIP_COL_FIRST = 2;
  localparam int DIP_COL_LAST  = 9;

  typedef logic [ROW_W-1:0]      kb_row_t;
  typedef logic [COL_W-1:0]      kb_col_t;
  typedef logic [KEY_CODE_W-1:0] key_code_t;

  // Named key codes.
  localparam key_code_t SHIFT  = 7'h00;
  localparam key_code_t CTRL   = 7'h01;
  localparam key_code_t ESCAPE = 7'h70;
  localparam key_code_t RETURN = 7'h49;

  // Field extraction for a key code or a PA_IN query address.
  function automatic kb_row_t code_row(input key_code_t code);
    return code[ROW_LSB +: ROW_W];
  endfunction

  function automatic kb_col_t code_col(input key_code_t code);
    return code[COL_LSB +: COL_W];
  endfunction

endpackage : bbc_keyboard_matrix_pkg

// File: rtl/bbc_keyboard_matrix_key_array.sv
// -----------------------------------------------------------------------------
// bbc_key_array
//
// Live key state for the BBC keyboard matrix: an 8 x 16 bit array written by
// make/break strobes, with the startup links overlaid on row 0 columns 2..9
// and unpopulated columns (NUM_COLS..15) forced to read as not pressed.
//
// Ports:
//   clk       in   state update clock (updates on the falling edge)
//   reset     in   synchronous active-high reset; clears every writable cell
//   wr_en     in   write strobe
//   wr_row    in   [2:0] row of the cell to write
//   wr_col    in   [3:0] column of the cell to write
//   wr_data   in   1 = pressed, 0 = released
//   rd_row    in   [2:0] random read row (PA7 query)
//   rd_col    in   [3:0] random read column (PA7 query)
//   rd_data   out  pressed state of the addressed cell, combinational
//   scan_col  in   [3:0] column selected for the column read port
//   col_data  out  [7:0] pressed state of every row in scan_col
// -----------------------------------------------------------------------------
module bbc_key_array
  import bbc_keyboard_matrix_pkg::*;
#(
  parameter logic [7:0] DIP_LINKS = 8'h00,
  parameter int         NUM_COLS  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [ROW_W-1:0]   wr_row,
  input  logic [COL_W-1:0]   wr_col,
  input  logic               wr_data,
  input  logic [ROW_W-1:0]   rd_row,
  input  logic [COL_W-1:0]   rd_col,
  output logic               rd_data,
  input  logic [COL_W-1:0]   scan_col,
  output logic [KB_ROWS-1:0] col_data
);

  logic [KB_ROWS-1:0][KB_COLS_MAX-1:0] keys_q;
  logic [KB_ROWS-1:0][KB_COLS_MAX-1:0] key_view;

  // A cell is writable unless it lies in an unpopulated column or is one of
  // the link cells. SHIFT (row 0 col 0) and CTRL (row 0 col 1) are writable.
  function automatic logic cell_writable(input logic [ROW_W-1:0] row,
                                         input logic [COL_W-1:0] col);
    logic populated;
    logic link_cell;
    populated = int'(col) < NUM_COLS;
    link_cell = (row == '0) && (int'(col) >= DIP_COL_FIRST) &&
                (int'(col) <= DIP_COL_LAST);
    return populated && !link_cell;
  endfunction

  // NOTE: the key array is a small flop array, not a RAM, so it is cleared by
  // reset like any other register; the masked cells are never written and so
  // stay at their reset value of zero.
  always_ff @(negedge clk) begin
    if (reset) begin
      // NOTE: sequential state is always updated with non-blocking assignments
      // so every register samples pre-edge values regardless of block order.
      keys_q <= '0;
    end else if (wr_en && cell_writable(wr_row, wr_col)) begin
      keys_q[wr_row][wr_col] <= wr_data;
    end
  end

  // Read view: stored state, then the link constants on row 0, then the
  // unpopulated columns forced low (a link beyond NUM_COLS also reads low).
  always_comb begin
    // NOTE: assigning the whole vector first gives every bit a value on every
    // path, so the overrides below cannot infer a latch.
    key_view = keys_q;
    for (int c = DIP_COL_FIRST; c <= DIP_COL_LAST; c++) begin
      key_view[0][c] = DIP_LINKS[c - DIP_COL_FIRST];
    end
    for (int c = 0; c < KB_COLS_MAX; c++) begin
      if (c >= NUM_COLS) begin
        for (int r = 0; r < KB_ROWS; r++) begin
          key_view[r][c] = 1'b0;
        end
      end
    end
  end

  assign rd_data = key_view[rd_row][rd_col];

  always_comb begin
    col_data = '0;
    for (int r = 0; r < KB_ROWS; r++) begin
      col_data[r] = key_view[r][scan_col];
    end
  end

endmodule : bbc_key_array

// File: rtl/bbc_keyboard_matrix.sv
// -----------------------------------------------------------------------------
// bbc_keyboard_matrix
//
// Peripheral-side model of the BBC micro keyboard matrix, sitting at the far
// end of the system VIA port A / CA2 interface. A host-side decoder updates
// the live key state through a make/break strobe. With the keyboard enabled
// (nKBEN=0) it answers addressed queries on PA7; with it disabled (nKBEN=1)
// it autoscans the columns and raises CA2 while any non-row-0 key in the
// column just presented is down.
//
// Ports:
//   PHI_2      in   system clock; all state updates on its falling edge
//   RESET      in   synchronous active-high reset
//   nKBEN      in   0 = addressed query mode, 1 = autoscan mode
//   PA_IN      in   [6:0] query address {row[2:0], col[3:0]}
//   PA7_OUT    out  pressed state of the queried key (0 while autoscanning)
//   CA2        out  registered keyboard interrupt request, active-high
//   KEY_VALID  in   one-cycle make/break strobe
//   KEY_CODE   in   [6:0] {row[2:0], col[3:0]} of the changing key
//   KEY_MAKE   in   1 = pressed, 0 = released
//   SCAN_COL   out  [3:0] current autoscan column
// -----------------------------------------------------------------------------
module bbc_keyboard_matrix
  import bbc_keyboard_matrix_pkg::*;
#(
  parameter logic [7:0] DIP_LINKS = 8'h00,
  parameter int         NUM_COLS  = 10
) (
  input  logic                  PHI_2,
  input  logic                  RESET,
  input  logic                  nKBEN,
  input  logic [KEY_CODE_W-1:0] PA_IN,
  output logic                  PA7_OUT,
  output logic                  CA2,
  input  logic                  KEY_VALID,
  input  logic [KEY_CODE_W-1:0] KEY_CODE,
  input  logic                  KEY_MAKE,
  output logic [COL_W-1:0]      SCAN_COL
);

  logic [COL_W-1:0]   scan_col_q;
  logic               ca2_q;
  logic               query_hit;
  logic [KB_ROWS-1:0] col_data;
  logic               col_any_key;

  bbc_key_array #(
    .DIP_LINKS (DIP_LINKS),
    .NUM_COLS  (NUM_COLS)
  ) u_key_array (
    .clk      (PHI_2),
    .reset    (RESET),
    .wr_en    (KEY_VALID),
    .wr_row   (code_row(KEY_CODE)),
    .wr_col   (code_col(KEY_CODE)),
    .wr_data  (KEY_MAKE),
    .rd_row   (code_row(PA_IN)),
    .rd_col   (code_col(PA_IN)),
    .rd_data  (query_hit),
    .scan_col (scan_col_q),
    .col_data (col_data)
  );

  // Row 0 holds SHIFT, CTRL and the links, none of which may interrupt.
  assign col_any_key = |col_data[KB_ROWS-1:1];

  // CA2 reflects the column presented before this edge and the key state
  // before any strobe on this edge, giving one cycle of latency. Leaving
  // autoscan drops CA2 on the next edge and freezes the column counter, so
  // scanning later resumes where it stopped.
  always_ff @(negedge PHI_2) begin
    if (RESET) begin
      scan_col_q <= '0;
      ca2_q      <= 1'b0;
    end else begin
      ca2_q <= nKBEN & col_any_key;
      if (nKBEN) begin
        scan_col_q <= scan_col_q + 4'd1;
      end
    end
  end

  // Zero-latency answer: the VIA samples PA7 in the same cycle it drives PA.
  assign PA7_OUT  = ~nKBEN & query_hit;
  assign CA2      = ca2_q;
  assign SCAN_COL = scan_col_q;

endmodule : bbc_keyboard_matrix

// File: tb/tb_bbc_keyboard_matrix.sv
// -----------------------------------------------------------------------------
// tb_bbc_keyboard_matrix
//
// Directed bench for bbc_keyboard_matrix with DIP_LINKS=8'hA5, NUM_COLS=10.
// Inputs are driven and outputs sampled just after the rising edge of PHI_2,
// half a cycle away from the falling edge where the design updates.
// -----------------------------------------------------------------------------
module tb_bbc_keyboard_matrix;
  import bbc_keyboard_matrix_pkg::*;

  logic       PHI_2 = 1'b1;
  logic       RESET;
  logic       nKBEN;
  logic [6:0] PA_IN;
  logic       PA7_OUT;
  logic       CA2;
  logic       KEY_VALID;
  logic [6:0] KEY_CODE;
  logic       KEY_MAKE;
  logic [3:0] SCAN_COL;

  int         checks   = 0;
  int         failures = 0;
  logic [3:0] exp_col;
  logic [3:0] steps_to_col;

  bbc_keyboard_matrix #(
    .DIP_LINKS (8'hA5),
    .NUM_COLS  (10)
  ) dut (
    .PHI_2     (PHI_2),
    .RESET     (RESET),
    .nKBEN     (nKBEN),
    .PA_IN     (PA_IN),
    .PA7_OUT   (PA7_OUT),
    .CA2       (CA2),
    .KEY_VALID (KEY_VALID),
    .KEY_CODE  (KEY_CODE),
    .KEY_MAKE  (KEY_MAKE),
    .SCAN_COL  (SCAN_COL)
  );

  always #10 PHI_2 = ~PHI_2;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [3:0] obs,
                       input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One PHI_2 cycle: track the expected column from the inputs applied to
  // this falling edge, then return 1 ns after the following rising edge.
  task automatic cyc();
    if (RESET)      exp_col = 4'd0;
    else if (nKBEN) exp_col = exp_col + 4'd1;
    @(negedge PHI_2);
    @(posedge PHI_2);
    #1;
  endtask

  task automatic strobe(input logic [6:0] code, input logic make);
    KEY_VALID = 1'b1;
    KEY_CODE  = code;
    KEY_MAKE  = make;
    cyc();
    KEY_VALID = 1'b0;
  endtask

  task automatic query(input string tag, input logic [6:0] addr,
                       input logic expv);
    PA_IN = addr;
    #1;
    check(tag, 4'(PA7_OUT), 4'(expv));
  endtask

  // Autoscan for n cycles. hot is the only column holding a non-row-0 key
  // (-1 for none), so CA2 is expected high only once the column after it is
  // showing.
  task automatic scan(input int n, input int hot);
    for (int i = 0; i < n; i++) begin
      cyc();
      check("scan_col", SCAN_COL, exp_col);
      check("scan_ca2", 4'(CA2),
            4'((hot >= 0) && (int'(exp_col) == ((hot + 1) % 16))));
      check("scan_pa7_low", 4'(PA7_OUT), 4'd0);
    end
  endtask

  initial begin
    RESET     = 1'b1;
    nKBEN     = 1'b0;
    PA_IN     = 7'h02;
    KEY_VALID = 1'b0;
    KEY_CODE  = 7'h00;
    KEY_MAKE  = 1'b0;
    exp_col   = 4'd0;

    // Reset; a make strobe during reset must be ignored.
    cyc();
    strobe(RETURN, 1'b1);
    check("rst_scan_col", SCAN_COL, 4'd0);
    check("rst_ca2", 4'(CA2), 4'd0);
    query("dip_col2", 7'h02, 1'b1);
    query("dip_col3", 7'h03, 1'b0);
    query("dip_col9", 7'h09, 1'b1);
    query("rst_shift_clear", SHIFT, 1'b0);
    query("rst_strobe_ignored", RETURN, 1'b0);
    RESET = 1'b0;

    // Make/break of RETURN visible to PA7 from the cycle after the strobe.
    PA_IN     = RETURN;
    KEY_VALID = 1'b1;
    KEY_CODE  = RETURN;
    KEY_MAKE  = 1'b1;
    #1;
    check("make_not_yet_visible", 4'(PA7_OUT), 4'd0);
    cyc();
    KEY_VALID = 1'b0;
    query("make_return", RETURN, 1'b1);
    strobe(RETURN, 1'b0);
    query("break_return", RETURN, 1'b0);
    check("query_scan_held", SCAN_COL, 4'd0);

    // RETURN (col 9) held: CA2 high only while SCAN_COL=10, every 16 cycles.
    strobe(RETURN, 1'b1);
    nKBEN = 1'b1;
    scan(32, 9);
    scan(10, 9);

    // Leaving autoscan drops CA2 and freezes the column; resume from it.
    nKBEN = 1'b0;
    cyc();
    check("freeze_col", SCAN_COL, 4'd10);
    check("freeze_ca2", 4'(CA2), 4'd0);
    cyc();
    check("frozen_col", SCAN_COL, 4'd10);
    nKBEN = 1'b1;
    scan(6, 9);

    // Break strobe while col 9 is presented: CA2 still uses the old value.
    scan(9, 9);
    strobe(RETURN, 1'b0);
    check("same_col_break_col", SCAN_COL, 4'd10);
    check("same_col_break_ca2", 4'(CA2), 4'd1);
    scan(16, -1);
    scan(15, -1);
    // Make strobe while col 9 is presented: seen only on the next visit.
    strobe(RETURN, 1'b1);
    check("same_col_make_ca2", 4'(CA2), 4'd0);
    scan(16, 9);
    strobe(RETURN, 1'b0);

    // SHIFT alone never interrupts, but reads pressed in query mode.
    nKBEN = 1'b0;
    strobe(SHIFT, 1'b1);
    nKBEN = 1'b1;
    scan(32, -1);
    nKBEN = 1'b0;
    query("shift_held", SHIFT, 1'b1);
    query("ctrl_clear", CTRL, 1'b0);

    // Two keys in col 0 (rows 7 and 1): CA2 is their OR.
    strobe(ESCAPE, 1'b1);
    strobe(7'h10, 1'b1);
    nKBEN = 1'b1;
    scan(16, 0);
    strobe(ESCAPE, 1'b0);
    scan(16, 0);
    nKBEN = 1'b0;
    strobe(7'h10, 1'b0);
    query("multi_released", 7'h10, 1'b0);

    // Writes to an unpopulated column and to a link cell are ignored.
    strobe(7'h4C, 1'b1);
    strobe(7'h05, 1'b1);
    query("col12_ignored", 7'h4C, 1'b0);
    query("dip_col5_ignored", 7'h05, 1'b0);
    query("dip_col4", 7'h04, 1'b1);
    nKBEN = 1'b1;
    scan(16, -1);

    // Reset mid-scan at column 6 with keys held.
    nKBEN = 1'b0;
    strobe(RETURN, 1'b1);
    nKBEN = 1'b1;
    steps_to_col = 4'd6 - exp_col;
    scan(int'(steps_to_col), 9);
    check("pre_reset_col", SCAN_COL, 4'd6);
    RESET = 1'b1;
    cyc();
    check("midscan_rst_col", SCAN_COL, 4'd0);
    check("midscan_rst_ca2", 4'(CA2), 4'd0);
    RESET = 1'b0;
    cyc();
    check("post_rst_col", SCAN_COL, 4'd1);
    check("post_rst_ca2", 4'(CA2), 4'd0);
    nKBEN = 1'b0;
    query("post_rst_return", RETURN, 1'b0);
    query("post_rst_shift", SHIFT, 1'b0);
    query("post_rst_dip", 7'h02, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_bbc_keyboard_matrix
